// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, access-size encodings and LSU state type.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/load_align.sv
// Right-aligns the addressed byte/half/word of a bus read word and sign- or
// zero-extends it. Purely combinational so other read paths can reuse it.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;
    logic            byte_sign;
    logic            half_sign;

    assign shifted   = rdata_i >> {offset_i, 3'b000};
    assign byte_sign = ~unsigned_i & shifted[7];
    assign half_sign = ~unsigned_i & shifted[15];

    always_comb begin
        case (size_i)
            SZ_BYTE: data_o = {{(XLEN-8){byte_sign}}, shifted[7:0]};
            SZ_HALF: data_o = {{(XLEN-16){half_sign}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: one valid/ready bus transaction per accepted
// access, registered bus outputs, aligned load result and pipeline stall.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            mem_rd_req_in,
    input  logic            mem_wr_req_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    input  logic [XLEN-1:0] iadder_out_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            misaligned_load_in,
    input  logic            misaligned_store_in,
    input  logic            trap_taken_in,
    output logic            dmem_req_out,
    output logic            dmem_we_out,
    output logic [XLEN-1:0] dmem_addr_out,
    output logic [XLEN-1:0] dmem_wdata_out,
    output logic [3:0]      dmem_wmask_out,
    input  logic            dmem_ready_in,
    input  logic [XLEN-1:0] dmem_rdata_in,
    output logic [XLEN-1:0] load_data_out,
    output logic            load_valid_out,
    output logic            stall_out
);

    lsu_state_e      state_q,     state_d;
    logic            req_q,       req_d;
    logic            we_q,        we_d;
    logic [XLEN-1:0] addr_q,      addr_d;
    logic [XLEN-1:0] wdata_q,     wdata_d;
    logic [3:0]      wmask_q,     wmask_d;
    logic [1:0]      size_q,      size_d;
    logic            uns_q,       uns_d;
    logic [1:0]      offset_q,    offset_d;
    logic            trap_seen_q, trap_seen_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            access_ok;
    logic            accept;
    logic [3:0]      wmask_new;
    logic [XLEN-1:0] wdata_new;
    logic [XLEN-1:0] aligned_data;

    // A store wins when both requests are raised; either misaligned flag kills it.
    assign access_ok = mem_wr_req_in
                     ? (~misaligned_store_in & ~(mem_rd_req_in & misaligned_load_in))
                     : (mem_rd_req_in & ~misaligned_load_in);
    assign accept    = (state_q == LSU_IDLE) & ~trap_taken_in & access_ok;

    always_comb begin
        wmask_new = 4'b0000;
        wdata_new = rs2_in;
        case (load_size_in)
            SZ_BYTE: begin
                wmask_new = 4'b0001 << iadder_out_in[1:0];
                wdata_new = {4{rs2_in[7:0]}};
            end
            SZ_HALF: begin
                wmask_new = 4'b0011 << {iadder_out_in[1], 1'b0};
                wdata_new = {2{rs2_in[15:0]}};
            end
            default: begin
                wmask_new = 4'b1111;
                wdata_new = rs2_in;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i    (dmem_rdata_in),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (aligned_data)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        size_d      = size_q;
        uns_d       = uns_q;
        offset_d    = offset_q;
        trap_seen_d = trap_seen_q;
        load_data_d = load_data_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    state_d     = LSU_BUSY;
                    req_d       = 1'b1;
                    we_d        = mem_wr_req_in;
                    addr_d      = {iadder_out_in[XLEN-1:2], 2'b00};
                    wdata_d     = wdata_new;
                    wmask_d     = mem_wr_req_in ? wmask_new : 4'b0000;
                    size_d      = load_size_in;
                    uns_d       = load_unsigned_in;
                    offset_d    = iadder_out_in[1:0];
                    trap_seen_d = 1'b0;
                end
            end
            LSU_BUSY: begin
                // A trap never aborts the bus cycle; it only drops the load result.
                if (trap_taken_in) begin
                    trap_seen_d = 1'b1;
                end
                if (dmem_ready_in) begin
                    state_d = LSU_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        load_data_d = aligned_data;
                    end
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= LSU_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= 4'b0000;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            offset_q    <= 2'b00;
            trap_seen_q <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            offset_q    <= offset_d;
            trap_seen_q <= trap_seen_d;
            load_data_q <= load_data_d;
        end
    end

    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = addr_q;
    assign dmem_wdata_out = wdata_q;
    assign dmem_wmask_out = wmask_q;
    assign load_data_out  = load_data_q;
    // Stall drops in DONE so the stage advances while the result is presented.
    assign load_valid_out = (state_q == LSU_DONE) & ~we_q & ~trap_seen_q & ~trap_taken_in;
    assign stall_out      = accept | (state_q == LSU_BUSY);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model, random-wait bus responder.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        mem_rd_req_in, mem_wr_req_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] iadder_out_in, rs2_in;
    logic        misaligned_load_in, misaligned_store_in, trap_taken_in;
    logic        dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]  dmem_wmask_out;
    logic        dmem_ready_in;
    logic [31:0] dmem_rdata_in;
    logic [31:0] load_data_out;
    logic        load_valid_out, stall_out;

    load_store_unit dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .mem_rd_req_in       (mem_rd_req_in),
        .mem_wr_req_in       (mem_wr_req_in),
        .load_size_in        (load_size_in),
        .load_unsigned_in    (load_unsigned_in),
        .iadder_out_in       (iadder_out_in),
        .rs2_in              (rs2_in),
        .misaligned_load_in  (misaligned_load_in),
        .misaligned_store_in (misaligned_store_in),
        .trap_taken_in       (trap_taken_in),
        .dmem_req_out        (dmem_req_out),
        .dmem_we_out         (dmem_we_out),
        .dmem_addr_out       (dmem_addr_out),
        .dmem_wdata_out      (dmem_wdata_out),
        .dmem_wmask_out      (dmem_wmask_out),
        .dmem_ready_in       (dmem_ready_in),
        .dmem_rdata_in       (dmem_rdata_in),
        .load_data_out       (load_data_out),
        .load_valid_out      (load_valid_out),
        .stall_out           (stall_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] load_q[$];
    logic [7:0]  ref_mem [64];
    logic [31:0] bus_mem [16];
    int          total = 0;
    int          bad = 0;
    int          forced_waits = -1;
    int          last_waits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    // Reads the addressed bytes of the word; bytes past the word end read as zero.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        int base, o, n;
        v = 0;
        base = int'({a[5:2], 2'b00});
        o = int'(a[1:0]);
        n = size_bytes(sz);
        for (int k = 0; k < n; k++)
            if (o + k < 4) v[8*k +: 8] = ref_mem[base + o + k];
        if (n == 1) v = uns ? {24'h0, v[7:0]} : 32'($signed(v[7:0]));
        if (n == 2) v = uns ? {16'h0, v[15:0]} : 32'($signed(v[15:0]));
        return v;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        bus_mem[a[5:2]] = w;
        for (int k = 0; k < 4; k++) ref_mem[int'({a[5:2], 2'b00}) + k] = w[8*k +: 8];
    endtask

    // Bus responder: random (or forced) wait count, junk rdata except on the ready cycle.
    initial begin : responder
        int waits;
        bit in_txn;
        waits = 0;
        in_txn = 0;
        dmem_ready_in = 1'b0;
        dmem_rdata_in = 32'h0;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_in || !dmem_req_out) begin
                dmem_ready_in = 1'b0;
                dmem_rdata_in = $urandom;
                in_txn = 0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1;
                    waits = (forced_waits >= 0) ? forced_waits : int'($urandom_range(0, 3));
                    last_waits = waits;
                end
                if (waits == 0) begin
                    dmem_ready_in = 1'b1;
                    dmem_rdata_in = bus_mem[dmem_addr_out[5:2]];
                    in_txn = 0;
                end else begin
                    dmem_ready_in = 1'b0;
                    dmem_rdata_in = $urandom;
                    waits--;
                end
            end
        end
    end

    // Bus monitor: every request cycle must match the oldest expected transaction.
    always @(negedge clk_in) begin : bus_mon
        bus_t e;
        if (!rst_in && dmem_req_out) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_req", 32'(dmem_req_out), 32'd0);
            end else begin
                e = bus_q[0];
                chk("bus_we", 32'(dmem_we_out), 32'(e.we));
                chk("bus_addr", dmem_addr_out, e.addr);
                chk("bus_wmask", 32'(dmem_wmask_out), 32'(e.wmask));
                if (e.we) chk("bus_wdata", dmem_wdata_out, e.wdata);
                if (dmem_ready_in) begin
                    void'(bus_q.pop_front());
                    if (dmem_we_out)
                        for (int k = 0; k < 4; k++)
                            if (dmem_wmask_out[k])
                                bus_mem[dmem_addr_out[5:2]][8*k +: 8] = dmem_wdata_out[8*k +: 8];
                end
            end
        end
    end

    always @(negedge clk_in) begin : load_mon
        logic [31:0] exp_v;
        if (!rst_in && load_valid_out) begin
            if (load_q.size() == 0) begin
                chk("load_unexpected_valid", 32'(load_valid_out), 32'd0);
            end else begin
                exp_v = load_q.pop_front();
                $display("load result %h expected %h", load_data_out, exp_v);
                chk("load_data", load_data_out, exp_v);
            end
        end
    end

    task automatic clear_inputs();
        mem_rd_req_in = 0;
        mem_wr_req_in = 0;
        misaligned_load_in = 0;
        misaligned_store_in = 0;
        trap_taken_in = 0;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] rs2, input bit mis_l,
                         input bit mis_s, input bit trap_acc, input bit trap_busy, input string tag);
        bit acc, is_load, done;
        int n, o, stall_n;
        bus_t e;
        acc = (rd || wr) && !((rd && mis_l) || (wr && mis_s)) && !trap_acc;
        is_load = rd && !wr;
        @(posedge clk_in);
        #1;
        mem_rd_req_in = rd;
        mem_wr_req_in = wr;
        load_size_in = sz;
        load_unsigned_in = uns;
        iadder_out_in = a;
        rs2_in = rs2;
        misaligned_load_in = mis_l;
        misaligned_store_in = mis_s;
        trap_taken_in = trap_acc;
        #1;
        chk({tag, "_stall_accept"}, 32'(stall_out), 32'(acc));
        if (acc) begin
            n = size_bytes(sz);
            o = int'(a[1:0]);
            e.we = wr;
            e.addr = {a[31:2], 2'b00};
            e.wmask = 4'b0000;
            e.wdata = (n == 1) ? {4{rs2[7:0]}} : (n == 2) ? {2{rs2[15:0]}} : rs2;
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    e.wmask[o + k] = 1'b1;
                    ref_mem[int'({a[5:2], 2'b00}) + o + k] = rs2[8*k +: 8];
                end
            end else if (!trap_busy) begin
                load_q.push_back(model_load(a, sz, uns));
            end
            bus_q.push_back(e);
        end
        @(posedge clk_in);
        #1;
        clear_inputs();
        trap_taken_in = acc && trap_busy;
        #1;
        if (!acc) begin
            chk({tag, "_no_req"}, 32'(dmem_req_out), 32'd0);
            chk({tag, "_no_stall"}, 32'(stall_out), 32'd0);
            $display("txn %s suppressed", tag);
            return;
        end
        chk({tag, "_req_rise"}, 32'(dmem_req_out), 32'd1);
        stall_n = 1;
        done = 0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk_in);
                #1;
                trap_taken_in = 0;
                #1;
            end
            if (stall_out) stall_n++;
            else begin
                done = 1;
                break;
            end
        end
        trap_taken_in = 0;
        if (!done) begin
            $display("FAIL %s_timeout actual=stall_stuck required=done", tag);
            bad++;
            total++;
            return;
        end
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(2 + last_waits));
        chk({tag, "_valid_done"}, 32'(load_valid_out), 32'(is_load && !trap_busy));
        $display("txn %s we=%0d addr=%h waits=%0d stall=%0d", tag, wr, a, last_waits, stall_n);
    endtask

    task automatic reset_mid();
        @(posedge clk_in);
        #1;
        mem_wr_req_in = 1;
        load_size_in = SZ_WORD;
        iadder_out_in = 32'h0000_0010;
        rs2_in = 32'hA5A5_1234;
        #1;
        chk("rst_mid_stall_accept", 32'(stall_out), 32'd1);
        @(posedge clk_in);
        #1;
        clear_inputs();
        rst_in = 1;
        #1;
        chk("rst_mid_req", 32'(dmem_req_out), 32'd0);
        chk("rst_mid_we", 32'(dmem_we_out), 32'd0);
        chk("rst_mid_addr", dmem_addr_out, 32'd0);
        chk("rst_mid_wdata", dmem_wdata_out, 32'd0);
        chk("rst_mid_wmask", 32'(dmem_wmask_out), 32'd0);
        chk("rst_mid_ldata", load_data_out, 32'd0);
        chk("rst_mid_valid", 32'(load_valid_out), 32'd0);
        chk("rst_mid_stall", 32'(stall_out), 32'd0);
        $display("txn reset during BUSY");
        @(posedge clk_in);
        #1;
        rst_in = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] a, r;
        logic [1:0] sz;
        int kind;
        bit mis;
        rst_in = 1;
        clear_inputs();
        load_size_in = 0;
        load_unsigned_in = 0;
        iadder_out_in = 0;
        rs2_in = 0;
        for (int i = 0; i < 16; i++) set_word(32'(i * 4), $urandom);
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_req", 32'(dmem_req_out), 32'd0);
        chk("reset_addr", dmem_addr_out, 32'd0);
        chk("reset_wmask", 32'(dmem_wmask_out), 32'd0);
        chk("reset_ldata", load_data_out, 32'd0);
        chk("reset_valid", 32'(load_valid_out), 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        rst_in = 0;

        forced_waits = 0;
        set_word(32'h100, 32'hDEAD_BEEF);
        issue(1, 0, SZ_WORD, 0, 32'h100, 0, 0, 0, 0, 0, "lw");
        set_word(32'h100, 32'h8011_2233);
        issue(1, 0, SZ_BYTE, 0, 32'h103, 0, 0, 0, 0, 0, "lb");
        issue(1, 0, SZ_BYTE, 1, 32'h103, 0, 0, 0, 0, 0, "lbu");
        issue(1, 0, SZ_HALF, 0, 32'h102, 0, 0, 0, 0, 0, "lh");
        issue(1, 0, SZ_HALF, 1, 32'h100, 0, 0, 0, 0, 0, "lhu");
        issue(0, 1, SZ_BYTE, 0, 32'h201, 32'h0000_00AB, 0, 0, 0, 0, "sb");
        issue(1, 0, SZ_WORD, 0, 32'h200, 0, 0, 0, 0, 0, "lw_after_sb");
        forced_waits = 3;
        issue(1, 0, SZ_WORD, 0, 32'h108, 0, 0, 0, 0, 0, "lw_wait3");
        issue(0, 1, SZ_HALF, 0, 32'h10E, 32'h1234_CAFE, 0, 0, 0, 0, "sh_wait3");
        forced_waits = 0;
        issue(1, 0, SZ_WORD, 0, 32'h102, 0, 1, 0, 0, 0, "lw_misaligned");
        issue(1, 0, SZ_WORD, 0, 32'h104, 0, 0, 0, 0, 1, "lw_trap_busy");
        issue(1, 0, SZ_WORD, 0, 32'h104, 0, 0, 0, 1, 0, "lw_trap_accept");
        issue(1, 1, SZ_WORD, 0, 32'h10C, 32'h0BAD_F00D, 0, 0, 0, 0, "rd_wr_both");
        issue(1, 1, SZ_WORD, 0, 32'h10E, 32'h0, 1, 0, 0, 0, "rd_wr_mis");
        issue(1, 0, 2'b11, 0, 32'h10C, 0, 0, 0, 0, 0, "lw_size3");
        reset_mid();
        issue(1, 0, SZ_WORD, 0, 32'h110, 0, 0, 0, 0, 0, "lw_after_reset");

        forced_waits = -1;
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 9));
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            r = $urandom;
            mis = ($urandom_range(0, 9) == 0);
            if (!mis) begin
                if (sz == SZ_HALF) a[0] = 1'b0;
                else if (sz != SZ_BYTE) a[1:0] = 2'b00;
            end
            issue(kind < 5, kind >= 5, sz, 1'($urandom), a, r, mis && kind < 5, mis && kind >= 5,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, "rand");
        end

        repeat (4) @(posedge clk_in);
        #1;
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("load_queue_drained", 32'(load_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
